// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard/forwarding unit.
//   fwd_sel_t   - operand source select driven onto FORWARD
//   haz_state_t - load-use stall state machine encoding
package hazard_pkg;

    localparam int unsigned FWD_W = 2;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } haz_state_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding select for a single EX-stage source operand.
// Ports:
//   i_src             - EX-stage source register address
//   i_rd_ex_mem       - destination in MEM, i_regwrite_ex_mem its write enable
//   i_rd_mem_wb       - destination in WB,  i_regwrite_mem_wb its write enable
//   o_sel             - FWD_EX_MEM / FWD_MEM_WB / FWD_RF (x0 never forwarded)
module fwd_select
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_rd_ex_mem,
    input  logic              i_regwrite_ex_mem,
    input  logic [ADDR_W-1:0] i_rd_mem_wb,
    input  logic              i_regwrite_mem_wb,
    output fwd_sel_t          o_sel
);

    // Younger producer (EX/MEM) is evaluated last so it takes priority.
    always_comb begin
        o_sel = FWD_RF;
        if (i_regwrite_mem_wb && (i_rd_mem_wb != '0) && (i_rd_mem_wb == i_src)) begin
            o_sel = FWD_MEM_WB;
        end
        if (i_regwrite_ex_mem && (i_rd_ex_mem != '0) && (i_rd_ex_mem == i_src)) begin
            o_sel = FWD_EX_MEM;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding, load-use stall and branch flush.
// Ports:
//   CLK, RST               - clock, synchronous active-high reset
//   ARS_ID_EX / ARS_IF_ID  - packed EX / ID source addresses (NUM_SRC x ADDR_W)
//   ARS_USED_IF_ID         - per-operand "really read" flags for ID
//   ARD_ID_EX, MEMREAD_ID_EX            - EX destination and load flag
//   ARD_EX_MEM, REGWRITE_EX_MEM         - MEM destination and write enable
//   ARD_MEM_WB, REGWRITE_MEM_WB         - WB destination and write enable
//   BRANCH_TAKEN           - taken branch resolved in EX
//   FORWARD                - 2-bit select per EX operand (combinational)
//   STALL, BUBBLE, FLUSH   - pipeline control (combinational)
//   STALL_COUNT            - saturating stall-cycle counter, only when
//                            HAZARD_STATS_EN is defined
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_SRC*ADDR_W-1:0]   ARS_ID_EX,
    input  logic [NUM_SRC*ADDR_W-1:0]   ARS_IF_ID,
    input  logic [NUM_SRC-1:0]          ARS_USED_IF_ID,
    input  logic [ADDR_W-1:0]           ARD_ID_EX,
    input  logic                        MEMREAD_ID_EX,
    input  logic [ADDR_W-1:0]           ARD_EX_MEM,
    input  logic                        REGWRITE_EX_MEM,
    input  logic [ADDR_W-1:0]           ARD_MEM_WB,
    input  logic                        REGWRITE_MEM_WB,
    input  logic                        BRANCH_TAKEN,
    output logic [FWD_W*NUM_SRC-1:0]    FORWARD,
    output logic                        STALL,
    output logic                        BUBBLE,
    output logic                        FLUSH
`ifdef HAZARD_STATS_EN
   ,output logic [31:0]                 STALL_COUNT
`endif
);

    localparam int unsigned CNT_W = $clog2(LOAD_LAT + 1);

    haz_state_t          r_state;
    haz_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_hit;
    logic                w_stall;
    logic                w_bubble;
    logic                w_flush;
    logic [FWD_W*NUM_SRC-1:0] w_fwd;

    // One select unit per EX operand.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
        fwd_sel_t w_sel;
        fwd_select #(.ADDR_W(ADDR_W)) u_fwd_select (
            .i_src             (ARS_ID_EX[k*ADDR_W +: ADDR_W]),
            .i_rd_ex_mem       (ARD_EX_MEM),
            .i_regwrite_ex_mem (REGWRITE_EX_MEM),
            .i_rd_mem_wb       (ARD_MEM_WB),
            .i_regwrite_mem_wb (REGWRITE_MEM_WB),
            .o_sel             (w_sel)
        );
        assign w_fwd[k*FWD_W +: FWD_W] = w_sel;
    end

    assign FORWARD = RST ? '0 : w_fwd;

    // Load-use hit: a load in EX whose non-x0 destination is read in ID.
    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (ARS_USED_IF_ID[k] && (ARS_IF_ID[k*ADDR_W +: ADDR_W] == ARD_ID_EX)) begin
                w_hit = 1'b1;
            end
        end
        if (!MEMREAD_ID_EX || (ARD_ID_EX == '0)) begin
            w_hit = 1'b0;
        end
    end

    // Stall FSM next-state/outputs; reset, then branch flush, override all.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_flush     = 1'b0;
        if (RST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (BRANCH_TAKEN) begin
            w_flush     = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                        if (LOAD_LAT > 1) begin
                            w_state_nxt = HOLD;
                            w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
                        end
                    end
                end
                HOLD: begin
                    w_stall  = 1'b1;
                    w_bubble = 1'b1;
                    // Last hold cycle at CNT==1; clamp so CNT never wraps.
                    if (r_cnt <= CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State and hold counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign STALL  = w_stall;
    assign BUBBLE = w_bubble;
    assign FLUSH  = w_flush;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_count;

    // Saturating count of stalled cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign STALL_COUNT = r_stall_count;
`endif

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard unit for the pipelined core, sitting between the ID, EX, MEM and WB pipeline registers. Per EX-stage source operand it computes forwarding selects from EX/MEM and MEM/WB, never forwarding register x0. It detects load-use hazards in ID and holds the front of the pipeline for a configurable memory-read latency through a small state machine. It also flushes IF/ID on a taken branch, with the flush overriding any stall.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NUM_SRC, 2, source operands per instruction (≥1)
- LOAD_LAT, 1, stall cycles per load-use hazard (≥1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- ARS_ID_EX  in  NUM_SRC*ADDR_W  EX-stage sources; operand k at [k*ADDR_W +: ADDR_W]
- ARS_IF_ID  in  NUM_SRC*ADDR_W  ID-stage sources, same packing
- ARS_USED_IF_ID  in  NUM_SRC  bit k = ID operand k actually read
- ARD_ID_EX  in  ADDR_W  destination of instruction in EX
- MEMREAD_ID_EX  in  1  instruction in EX is a load
- ARD_EX_MEM  in  ADDR_W  destination in MEM
- REGWRITE_EX_MEM  in  1  MEM instruction writes the register file
- ARD_MEM_WB  in  ADDR_W  destination in WB
- REGWRITE_MEM_WB  in  1  WB instruction writes the register file
- BRANCH_TAKEN  in  1  branch resolved taken in EX
- FORWARD  out  2*NUM_SRC  select for operand k at [2k +: 2]
- STALL  out  1  hold PC and IF/ID
- BUBBLE  out  1  zero ID/EX control
- FLUSH  out  1  clear IF/ID
- STALL_COUNT  out  32  stall-cycle counter (HAZARD_STATS_EN only)

## Operation
- Forward select per operand k, with s = ARS_ID_EX operand k:
  - 2'b10 if REGWRITE_EX_MEM, ARD_EX_MEM≠0 and ARD_EX_MEM==s.
  - Else 2'b01 if REGWRITE_MEM_WB, ARD_MEM_WB≠0 and ARD_MEM_WB==s.
  - Else 2'b00.
  - EX/MEM has priority over MEM/WB. Encoding 2'b11 is never produced.
- Load-use hit: MEMREAD_ID_EX, ARD_ID_EX≠0, and for some k ARS_USED_IF_ID[k] with operand k of ARS_IF_ID == ARD_ID_EX.
- FSM states:
  - IDLE: on a hit without BRANCH_TAKEN, STALL=BUBBLE=1 this cycle. If LOAD_LAT>1, go to HOLD with CNT←LOAD_LAT−1; otherwise stay in IDLE.
  - HOLD: STALL=BUBBLE=1. CNT decrements each cycle. When CNT==1, next state is IDLE. New hits are ignored while in HOLD.
- BRANCH_TAKEN, in any state: FLUSH=1, STALL=BUBBLE=0, next state IDLE, CNT←0. A stall in progress is aborted.
- Total stall per hazard is exactly LOAD_LAT consecutive cycles.

## Timing
- FORWARD, STALL, BUBBLE and FLUSH are combinational from inputs and the current state, valid in the same cycle. Forwarding has zero latency.
- State and CNT update on the CLK edge.
- While RST=1: all outputs 0 and FORWARD=0. State←IDLE, CNT←0, STALL_COUNT←0 at the edge.
- RST asserted mid-HOLD: the stall ends immediately and the next cycle starts in IDLE.
- CNT width is $clog2(LOAD_LAT+1). CNT never wraps.
- Hit and BRANCH_TAKEN in the same cycle: the flush wins and no stall occurs.

## Configuration
- HAZARD_STATS_EN defined:
  - STALL_COUNT port exists.
  - It increments by 1 at each edge where STALL=1 and RST=0.
  - It saturates at 32'hFFFF_FFFF.
- HAZARD_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10.
  - haz_state_t enum: IDLE, HOLD.
- Sub-module fwd_select computes the 2-bit select for one operand. It is instantiated NUM_SRC times in a generate loop.
- FSM, CNT and the stats counter live in the top level.

## Test plan
- Forward priority: ARS_ID_EX op0=op1=3, ARD_EX_MEM=3, ARD_MEM_WB=3, both REGWRITE=1 -> FORWARD=4'b1010.
- x0 guard: op0=0, ARD_EX_MEM=0, REGWRITE_EX_MEM=1 -> FORWARD[1:0]=2'b00.
- Single-cycle load-use (LOAD_LAT=1): MEMREAD_ID_EX=1, ARD_ID_EX=5, ARS_IF_ID op1=5, ARS_USED_IF_ID=2'b10 -> STALL=BUBBLE=1 for exactly 1 cycle. Same with ARS_USED_IF_ID=2'b01 -> no stall.
- Multi-cycle load-use (LOAD_LAT=3): hit held 1 cycle -> STALL high 3 consecutive cycles, then 0. STALL_COUNT=3 with HAZARD_STATS_EN.
- Abort: LOAD_LAT=3, BRANCH_TAKEN=1 in the second stall cycle -> FLUSH=1 and STALL=0 that cycle, IDLE next cycle.
- Mid-stall reset: LOAD_LAT=4, RST=1 in the second stall cycle -> all outputs 0, STALL_COUNT=0, no further stall after RST drops.
